// File: rtl/pusch_iq_output_framer_if.sv
// I/Q sample stream into the framer and packed word stream out to the DAC.
// master drives samples and consumes words; slave is the framer.
interface pusch_iq_output_framer_if #(
    parameter int IN_WIDTH  = 26,
    parameter int OUT_WIDTH = 16
);
    logic signed [IN_WIDTH-1:0] in_r;
    logic signed [IN_WIDTH-1:0] in_i;
    logic                       in_valid;
    logic [2*OUT_WIDTH-1:0]     out_iq;
    logic                       out_sos;
    logic                       out_eos;
    logic                       out_valid;
    logic                       out_ready;

    modport master (
        output in_r,
        output in_i,
        output in_valid,
        output out_ready,
        input  out_iq,
        input  out_sos,
        input  out_eos,
        input  out_valid
    );

    modport slave (
        input  in_r,
        input  in_i,
        input  in_valid,
        input  out_ready,
        output out_iq,
        output out_sos,
        output out_eos,
        output out_valid
    );
endinterface

// File: rtl/pusch_iq_output_framer.sv
// PUSCH output framer: round/saturate IFFT samples, tag symbol/slot
// boundaries, and buffer packed I/Q words in a show-ahead FIFO.
module pusch_iq_output_framer #(
    parameter int unsigned IN_WIDTH      = 26,
    parameter int unsigned OUT_WIDTH     = 16,
    parameter int unsigned SHIFT         = 10,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned SYM_LEN       = 2192,
    parameter int unsigned SYMS_PER_SLOT = 14
) (
    input  logic                          clk,
    input  logic                          reset,
    pusch_iq_output_framer_if.slave       bus,
    input  logic                          clr_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int SCW = $clog2(SYM_LEN);
    localparam int SYW = $clog2(SYMS_PER_SLOT);
    localparam int EW  = 2 * OUT_WIDTH + 2;

    localparam logic signed [IN_WIDTH:0] RND =
        (IN_WIDTH+1)'(2 ** (SHIFT - 1));
    localparam logic signed [IN_WIDTH:0] Y_MAX =
        (IN_WIDTH+1)'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [IN_WIDTH:0] Y_MIN =
        (IN_WIDTH+1)'(-(2 ** (OUT_WIDTH - 1)));

    localparam logic [SCW-1:0] SC_LAST = SCW'(SYM_LEN - 1);
    localparam logic [SYW-1:0] SY_LAST = SYW'(SYMS_PER_SLOT - 1);
    localparam logic [PW:0]    LVL_FULL = (PW+1)'(FIFO_DEPTH);

    generate
        if (SHIFT < 1 || SHIFT > IN_WIDTH - 1) begin : g_bad_shift
            $error("SHIFT out of range");
        end
        if ((1 << PW) != FIFO_DEPTH) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of 2");
        end
    endgenerate

    // Round half up, then clamp to the signed output range.
    function automatic logic [OUT_WIDTH-1:0] scale(
        input logic signed [IN_WIDTH-1:0] x
    );
        logic signed [IN_WIDTH:0] t;
        logic signed [IN_WIDTH:0] y;
        t = $signed({x[IN_WIDTH-1], x}) + RND;
        y = t >>> SHIFT;
        if (y > Y_MAX) begin
            scale = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else if (y < Y_MIN) begin
            scale = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            scale = y[OUT_WIDTH-1:0];
        end
    endfunction

    logic [SCW-1:0] sample_cnt;
    logic [SYW-1:0] sym_cnt;
    logic           sample_last;
    logic           sym_last;

    assign sample_last = (sample_cnt == SC_LAST);
    assign sym_last    = (sym_cnt == SY_LAST);

    // Counters follow the air timeline, so dropped samples still count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_cnt <= '0;
            sym_cnt    <= '0;
        end else if (bus.in_valid) begin
            if (sample_last) begin
                sample_cnt <= '0;
                sym_cnt    <= sym_last ? '0 : sym_cnt + SYW'(1);
            end else begin
                sample_cnt <= sample_cnt + SCW'(1);
            end
        end
    end

    logic          st_valid;
    logic [EW-1:0] st_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_valid <= 1'b0;
            st_data  <= '0;
        end else begin
            st_valid <= bus.in_valid;
            if (bus.in_valid) begin
                st_data <= {scale(bus.in_r), scale(bus.in_i),
                            sample_cnt == '0,
                            sample_last && sym_last};
            end
        end
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   level;
    logic [EW-1:0] last_word;
    logic [EW-1:0] head;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;

    assign empty = (level == '0);
    assign full  = (level == LVL_FULL);
    assign pop   = !empty && bus.out_ready;
    assign push  = st_valid && (!full || pop);
    assign drop  = st_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= st_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            last_word <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PW'(1);
                last_word <= mem[rd_ptr];
            end
            unique case ({push, pop})
                2'b10:   level <= level + (PW+1)'(1);
                2'b01:   level <= level - (PW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // A clear in the same cycle as a drop leaves the flag low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    // When drained, the outputs keep showing the last word handed out.
    assign head          = empty ? last_word : mem[rd_ptr];
    assign bus.out_iq    = head[EW-1:2];
    assign bus.out_sos   = head[1];
    assign bus.out_eos   = head[0];
    assign bus.out_valid = !empty;
    assign fifo_level    = level;

endmodule

// File: tb/tb_pusch_iq_output_framer.sv
// Scoreboard bench for pusch_iq_output_framer.
// Stimulus queues expected words; a negedge monitor pops and compares.
module tb_pusch_iq_output_framer;

    localparam int SYM_LEN = 2192;
    localparam int SYMS    = 14;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [4:0] fifo_level;
    logic       overflow;

    pusch_iq_output_framer_if #(.IN_WIDTH(26), .OUT_WIDTH(16)) bus ();

    pusch_iq_output_framer dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .clr_ovf    (clr_ovf),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_pop = 0;
    int sos_seen = 0;
    int eos_seen = 0;
    int m_sc = 0;
    int m_sym = 0;
    logic [33:0] sb [$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            n_pop++;
            if (bus.out_sos) sos_seen++;
            if (bus.out_eos) eos_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_word", {bus.out_iq, bus.out_sos,
                    bus.out_eos}, 64'hdead);
            end else begin
                chk("word", {bus.out_iq, bus.out_sos, bus.out_eos},
                    sb.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        reset = 1'b0;
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_word", {bus.out_iq, bus.out_sos, bus.out_eos}, 0);
        sb.delete();
        m_sc = 0;
        m_sym = 0;
        cyc();
        reset = 1'b1;
    endtask

    task automatic send(input logic signed [25:0] r,
                        input logic signed [25:0] i,
                        input logic [31:0] exp_iq, input bit kept);
        bus.in_r = r;
        bus.in_i = i;
        bus.in_valid = 1'b1;
        if (kept) begin
            sb.push_back({exp_iq, m_sc == 0,
                          (m_sc == SYM_LEN - 1) && (m_sym == SYMS - 1)});
        end
        if (m_sc == SYM_LEN - 1) begin
            m_sc = 0;
            m_sym = (m_sym == SYMS - 1) ? 0 : m_sym + 1;
        end else begin
            m_sc++;
        end
        cyc();
        bus.in_valid = 1'b0;
    endtask

    // k*1024 on I and -k*1024 on Q scale exactly to k and -k.
    task automatic send_k(input int k, input bit kept);
        logic [15:0] ei;
        logic [15:0] eq;
        ei = 16'(k);
        eq = 16'(-k);
        send(26'(k * 1024), 26'(-k * 1024), {ei, eq}, kept);
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            cyc();
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
        end
        repeat (3) cyc();
        chk("drained_valid", bus.out_valid, 0);
    endtask

    typedef struct {
        logic signed [25:0] r;
        logic signed [25:0] i;
        logic [31:0]        iq;
    } vec_t;

    vec_t vecs [9] = '{
        '{26'sd1023,     26'sd1536,   32'h0001_0002},
        '{26'sd512,      -26'sd1,     32'h0001_0000},
        '{26'sd511,      -26'sd1536,  32'h0000_FFFF},
        '{-26'sd512,     26'sd2047,   32'h0000_0002},
        '{-26'sd513,     -26'sd2049,  32'hFFFF_FFFE},
        '{26'sd33554431, -26'sd33554432, 32'h7FFF_8000},
        '{-26'sd33554432, 26'sd33554431, 32'h8000_7FFF},
        '{26'sd33553919, 26'sd0,      32'h7FFF_0000},
        '{26'sd33553920, 26'sd0,      32'h7FFF_0000}
    };

    int p0;

    initial begin
        bus.in_r = '0;
        bus.in_i = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;

        do_reset();
        bus.out_ready = 1'b1;
        foreach (vecs[v]) send(vecs[v].r, vecs[v].i, vecs[v].iq, 1'b1);
        wait_drain(64);

        do_reset();
        repeat (5) cyc();
        send_k(7, 1'b1);
        chk("lat_n1_valid", bus.out_valid, 0);
        cyc();
        chk("lat_n2_valid", bus.out_valid, 1);
        chk("lat_n2_sos", bus.out_sos, 1);
        wait_drain(16);

        do_reset();
        sos_seen = 0;
        eos_seen = 0;
        for (int n = 0; n < SYMS * SYM_LEN; n++) send_k(n & 255, 1'b1);
        wait_drain(64);
        chk("slot_sos_count", sos_seen, SYMS);
        chk("slot_eos_count", eos_seen, 1);

        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 16; k++) send_k(k, 1'b1);
        repeat (2) cyc();
        chk("bp_level16", fifo_level, 16);
        chk("bp_no_ovf", overflow, 0);
        send_k(17, 1'b0);
        repeat (2) cyc();
        chk("bp_drop_ovf", overflow, 1);
        chk("bp_drop_level", fifo_level, 16);
        p0 = n_pop;
        bus.out_ready = 1'b1;
        wait_drain(64);
        chk("bp_pop_count", n_pop - p0, 16);

        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k <= 16; k++) send_k(k, 1'b1);
        chk("pp_full_before", fifo_level, 16);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        chk("pp_level", fifo_level, 16);
        chk("pp_no_ovf", overflow, 0);
        send_k(17, 1'b0);
        cyc();
        chk("pp_drop_ovf", overflow, 1);
        send_k(18, 1'b0);
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        chk("clr_wins", overflow, 0);
        chk("clr_level", fifo_level, 16);
        bus.out_ready = 1'b1;
        wait_drain(64);

        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 8; k++) send_k(k, 1'b1);
        repeat (2) cyc();
        chk("mid_level8", fifo_level, 8);
        do_reset();
        bus.out_ready = 1'b1;
        send_k(3, 1'b1);
        wait_drain(16);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
